epg_tx_fsm: RTL

//  Ethernet packet generator: the transmit end of the byte-wide {data, control} link that the packet detector receives.

---
 rtl/epg_tx_fsm.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/epg_tx_fsm.sv
// Ethernet packet generator: serializes preamble/SFD, MAC header, payload
// (zero-padded to the minimum), CRC-32 FCS and the inter-frame gap onto a
// byte-wide {data, control} line. Payload arrives over a valid/ready stream.
module epg_tx_fsm #(
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int IFG_BYTES   = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] dst_addr,
    input  logic [47:0] src_addr,
    input  logic [15:0] type_length,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    input  logic        pl_last,
    output logic        pl_ready,
    output logic [7:0]  data,
    output logic        control,
    output logic        busy,
    output logic        tx_done,
    output logic        tx_underrun,
    output logic [3:0]  tx_frame_count
);

    typedef enum logic [3:0] {
        IDLE, PRE, DST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG
    } state_t;

    state_t      state, state_nx;
    logic [10:0] idx, idx_nx;
    logic [10:0] pcount, pcount_nx;
    logic [31:0] crc, crc_nx;
    logic [47:0] dst_q, src_q;
    logic [15:0] tl_q;
    logic [47:0] dst_sh, src_sh;
    logic [31:0] fcs_sh;
    logic [7:0]  data_nx;
    logic        control_nx, busy_nx, done_nx, underrun_nx;
    logic [3:0]  count_nx;

    // One byte of the reflected IEEE 802.3 CRC, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Payload byte counter increment, held at MAX_PAYLOAD.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v >= 11'(MAX_PAYLOAD)) ? v : v + 11'd1;
    endfunction

    // The block takes a payload byte whenever the next line byte is payload.
    assign pl_ready = (state == PAYLOAD);

    // Next-state, next line byte and CRC update for the byte leaving at the next edge.
    always_comb begin
        state_nx    = state;
        idx_nx      = idx + 11'd1;
        pcount_nx   = pcount;
        crc_nx      = crc;
        data_nx     = 8'h00;
        control_nx  = 1'b0;
        busy_nx     = busy;
        done_nx     = 1'b0;
        underrun_nx = 1'b0;
        count_nx    = tx_frame_count;
        dst_sh      = dst_q << {idx[2:0], 3'b000};
        src_sh      = src_q << {idx[2:0], 3'b000};
        fcs_sh      = ~crc >> {idx[1:0], 3'b000};

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = PRE;
                    busy_nx   = 1'b1;
                    crc_nx    = 32'hFFFFFFFF;
                    pcount_nx = '0;
                end
            end
            PRE: begin
                control_nx = 1'b1;
                data_nx    = (idx == 11'd7) ? 8'hD5 : 8'h55;
                if (idx == 11'd7) state_nx = DST;
            end
            DST: begin
                control_nx = 1'b1;
                data_nx    = dst_sh[47:40];
                crc_nx     = crc_byte(crc, data_nx);
                if (idx == 11'd5) state_nx = SRC;
            end
            SRC: begin
                control_nx = 1'b1;
                data_nx    = src_sh[47:40];
                crc_nx     = crc_byte(crc, data_nx);
                if (idx == 11'd5) state_nx = TYPE;
            end
            TYPE: begin
                control_nx = 1'b1;
                data_nx    = idx[0] ? tl_q[7:0] : tl_q[15:8];
                crc_nx     = crc_byte(crc, data_nx);
                if (idx == 11'd1) state_nx = PAYLOAD;
            end
            PAYLOAD: begin
                if (pl_valid) begin
                    control_nx = 1'b1;
                    data_nx    = pl_data;
                    crc_nx     = crc_byte(crc, data_nx);
                    pcount_nx  = sat_inc(pcount);
                    if (pl_last || pcount_nx == 11'(MAX_PAYLOAD)) begin
                        state_nx = (pcount_nx < 11'(MIN_PAYLOAD)) ? PAD : FCS;
                    end
                end else begin
                    // Starved line: abort the frame on this very edge.
                    underrun_nx = 1'b1;
                    state_nx    = IFG;
                end
            end
            PAD: begin
                control_nx = 1'b1;
                data_nx    = 8'h00;
                crc_nx     = crc_byte(crc, data_nx);
                pcount_nx  = sat_inc(pcount);
                if (pcount_nx >= 11'(MIN_PAYLOAD)) state_nx = FCS;
            end
            FCS: begin
                control_nx = 1'b1;
                data_nx    = fcs_sh[7:0];
                if (idx == 11'd3) begin
                    done_nx  = 1'b1;
                    count_nx = tx_frame_count + 4'd1;
                    state_nx = IFG;
                end
            end
            IFG: begin
                // busy drops early enough that a held start produces exactly
                // IFG_BYTES idle bytes between frames (accept edge is idle too).
                if (idx >= 11'(IFG_BYTES - 2)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase

        if (state_nx != state) idx_nx = '0;
    end

    // Control state and registered line outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            data           <= 8'h00;
            control        <= 1'b0;
            busy           <= 1'b0;
            tx_done        <= 1'b0;
            tx_underrun    <= 1'b0;
            tx_frame_count <= 4'd0;
        end else begin
            state          <= state_nx;
            idx            <= idx_nx;
            data           <= data_nx;
            control        <= control_nx;
            busy           <= busy_nx;
            tx_done        <= done_nx;
            tx_underrun    <= underrun_nx;
            tx_frame_count <= count_nx;
        end
    end

    // Datapath state: header latch on accept, CRC and payload count.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            dst_q <= dst_addr;
            src_q <= src_addr;
            tl_q  <= type_length;
        end
        crc    <= crc_nx;
        pcount <= pcount_nx;
    end

endmodule
